// File: rtl/program_loader.sv
// Purpose : encodes and validates decoded Z instructions and writes them into the instruction RAM.
// Latency : each RAM write appears 1 cycle after its handshake; the terminator follows the last write.
// Backpressure: in_ready is high only in LOAD; every valid cycle there is accepted.
//
// Ports:
//   clock, reset_n            - clock and synchronous active-low reset
//   load_start/run_stop/err_clr - control pulses (IDLE / RUN / ERR respectively)
//   in_valid/in_ready, in_*   - decoded instruction fields stream, in_last marks program end
//   addr/wEn/wDat             - instruction RAM write port
//   working                   - processor run enable
//   count, err, trunc         - load status
module program_loader #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              run_stop,
  input  logic              err_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic [15:0]       in_valC,
  input  logic              in_last,
  output logic [ADDR_W-1:0] addr,
  output logic              wEn,
  output logic [31:0]       wDat,
  output logic              working,
  output logic [ADDR_W:0]   count,
  output logic              err,
  output logic              trunc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TERM,
    S_RUN,
    S_ERR
  } state_t;

  // Count value that fills the RAM except for the terminator slot.
  localparam logic [ADDR_W:0] CNT_CAP = (ADDR_W+1)'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [31:0]         wdat_q, wdat_d;
  logic                working_q, working_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic                trunc_q, trunc_d;

  logic                is_irmov;
  logic                is_op;
  logic                legal;
  logic [31:0]         enc_word;
  logic [ADDR_W:0]     cnt_inc;

  // Instruction-set check and packing.
  always_comb begin
    is_irmov = (in_icode == 4'd3) && (in_ifun == 4'd0) && (in_rA == 4'hF) && (in_rB <= 4'd5);
    is_op    = (in_icode == 4'd6) && (in_ifun <= 4'd3) && (in_rA <= 4'd5) &&
               (in_rB <= 4'd5) && (in_valC == 16'd0);
    legal    = is_irmov || is_op;
    enc_word = {in_icode, in_ifun, in_rA, in_rB, in_valC};
    cnt_inc  = count_q + (ADDR_W+1)'(1);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    trunc_d   = trunc_q;
    addr_d    = '0;
    wen_d     = 1'b0;
    wdat_d    = '0;
    working_d = 1'b0;
    in_ready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          ptr_d   = '0;
          count_d = '0;
          trunc_d = 1'b0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (legal) begin
            wen_d   = 1'b1;
            addr_d  = ptr_q;
            wdat_d  = enc_word;
            ptr_d   = ptr_q + ADDR_W'(1);
            count_d = cnt_inc;
            if (in_last) begin
              state_d = S_TERM;
            end else if (cnt_inc == CNT_CAP) begin
              // Only the terminator slot is left: cut the program here.
              trunc_d = 1'b1;
              state_d = S_TERM;
            end
          end else begin
            // Illegal word is consumed but never written.
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
      end

      S_TERM: begin
        wen_d   = 1'b1;
        addr_d  = ptr_q;
        wdat_d  = '0;
        state_d = S_RUN;
      end

      S_RUN: begin
        // working is driven from the registered state, so it rises one cycle
        // after the terminator write and never overlaps a wEn pulse.
        if (run_stop) begin
          state_d = S_IDLE;
        end else begin
          working_d = 1'b1;
        end
      end

      S_ERR: begin
        if (err_clr) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdat_q    <= '0;
      working_q <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
      trunc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdat_q    <= wdat_d;
      working_q <= working_d;
      count_q   <= count_d;
      err_q     <= err_d;
      trunc_q   <= trunc_d;
    end
  end

  assign addr    = addr_q;
  assign wEn     = wen_q;
  assign wDat    = wdat_q;
  assign working = working_q;
  assign count   = count_q;
  assign err     = err_q;
  assign trunc   = trunc_q;

endmodule

// File: tb/tb_program_loader.sv
// Purpose : randomized self-checking bench for program_loader against a sequence-level model.
// Latency : model predicts the full write sequence per load; observed writes are logged and compared.
// Backpressure: stimulus inserts random in_valid gaps; in_ready is checked on every presented word.
module tb_program_loader;

  localparam int AW  = 4;
  localparam int DEP = 16;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          load_start, run_stop, err_clr;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_icode, in_ifun, in_rA, in_rB;
  logic [15:0]   in_valC;
  logic          in_last;
  logic [AW-1:0] addr;
  logic          wEn;
  logic [31:0]   wDat;
  logic          working;
  logic [AW:0]   count;
  logic          err;
  logic          trunc;

  program_loader #(.ADDR_W(AW), .DEPTH(DEP)) dut (
    .clock(clock), .reset_n(reset_n), .load_start(load_start), .run_stop(run_stop),
    .err_clr(err_clr), .in_valid(in_valid), .in_ready(in_ready), .in_icode(in_icode),
    .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB), .in_valC(in_valC), .in_last(in_last),
    .addr(addr), .wEn(wEn), .wDat(wDat), .working(working), .count(count), .err(err),
    .trunc(trunc)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Program under test and model outputs.
  logic [31:0] pw[$];
  bit          pl[$];
  logic [63:0] exp_q[$];
  logic [63:0] log_q[$];
  int          exp_cnt, n_acc;
  bit          exp_err, exp_trunc;

  // Write port monitor: records every RAM write, checks run-time invariants.
  always @(negedge clock) begin
    if (reset_n) begin
      if (wEn) log_q.push_back({32'(addr), wDat});
      check_eq("wen_and_working", 32'(wEn & working), 32'd0);
      if (working) check_eq("run_addr", 32'(addr), 32'd0);
    end
  end

  function automatic bit ref_legal(input logic [31:0] w);
    int ic = int'(w[31:28]);
    int fn = int'(w[27:24]);
    int ra = int'(w[23:20]);
    int rb = int'(w[19:16]);
    if (ic == 3) return (fn == 0) && (ra == 15) && (rb < 6);
    if (ic == 6) return (fn < 4) && (ra < 6) && (rb < 6) && (w[15:0] == 16'd0);
    return 1'b0;
  endfunction

  // Reference: walk the program, list the RAM writes the loader must produce.
  task automatic build_expect();
    exp_q.delete();
    exp_cnt = 0; exp_err = 0; exp_trunc = 0; n_acc = 0;
    for (int i = 0; i < pw.size(); i++) begin
      n_acc++;
      if (!ref_legal(pw[i])) begin
        exp_err = 1;
        break;
      end
      exp_q.push_back({32'(i), pw[i]});
      exp_cnt++;
      if (pl[i]) begin
        exp_q.push_back({32'(i + 1), 32'd0});
        break;
      end
      if (exp_cnt == DEP - 1) begin
        exp_trunc = 1;
        exp_q.push_back({32'(i + 1), 32'd0});
        break;
      end
    end
  endtask

  function automatic logic [31:0] rand_instr(input bit allow_bad);
    int r = allow_bad ? $urandom_range(0, 11) : $urandom_range(0, 7);
    if (r <= 3) return {4'h3, 4'h0, 4'hF, 4'($urandom_range(0, 5)), 16'($urandom)};
    if (r <= 7) return {4'h6, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 5)),
                        4'($urandom_range(0, 5)), 16'h0};
    if (r == 8) return {4'h6, 4'($urandom_range(4, 15)), 4'($urandom_range(0, 5)),
                        4'($urandom_range(0, 5)), 16'h0};
    if (r == 9) return {4'h3, 4'h0, 4'hF, 4'($urandom_range(6, 15)), 16'($urandom)};
    if (r == 10) return {4'h6, 4'h1, 4'h2, 4'h3, 16'($urandom_range(1, 65535))};
    return $urandom;
  endfunction

  task automatic drive_word(input logic [31:0] w, input bit last);
    {in_icode, in_ifun, in_rA, in_rB, in_valC} = w;
    in_last  = last;
    in_valid = 1'b1;
  endtask

  // One complete load: start pulse, stream the accepted words, then compare results.
  task automatic run_load(input bit hold_valid);
    log_q.delete();
    build_expect();
    @(negedge clock);
    check_eq("idle_ready", 32'(in_ready), 32'd0);
    load_start = 1'b1;
    if (hold_valid) drive_word(pw[0], pl[0]);
    @(negedge clock);
    load_start = 1'b0;
    for (int i = 0; i < n_acc; i++) begin
      if (!(hold_valid && i == 0)) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clock);
        drive_word(pw[i], pl[i]);
      end
      check_eq("load_ready", 32'(in_ready), 32'd1);
      @(negedge clock);
    end
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    check_eq("n_writes", 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check_eq("wr_addr", log_q[i][63:32], exp_q[i][63:32]);
      check_eq("wr_data", log_q[i][31:0], exp_q[i][31:0]);
    end
    check_eq("count", 32'(count), 32'(exp_cnt));
    check_eq("err", 32'(err), 32'(exp_err));
    check_eq("trunc", 32'(trunc), 32'(exp_trunc));
    check_eq("working", 32'(working), 32'(!exp_err));
    check_eq("post_ready", 32'(in_ready), 32'd0);
    check_eq("post_wen", 32'(wEn), 32'd0);
  endtask

  task automatic end_load();
    if (exp_err) begin
      err_clr = 1'b1;
      @(negedge clock);
      err_clr = 1'b0;
      check_eq("err_clr", 32'(err), 32'd0);
    end else begin
      run_stop = 1'b1;
      @(negedge clock);
      run_stop = 1'b0;
      check_eq("run_stop", 32'(working), 32'd0);
    end
    @(negedge clock);
    check_eq("back_idle_ready", 32'(in_ready), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; load_start = 0; run_stop = 0; err_clr = 0;
    in_valid = 0; in_icode = 0; in_ifun = 0; in_rA = 0; in_rB = 0; in_valC = 0; in_last = 0;
    repeat (2) @(negedge clock);
    check_eq("rst_addr", 32'(addr), 32'd0);
    check_eq("rst_wen", 32'(wEn), 32'd0);
    check_eq("rst_wdat", wDat, 32'd0);
    check_eq("rst_working", 32'(working), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    check_eq("rst_trunc", 32'(trunc), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b1;

    // Single IRMOV program.
    pw = '{32'h30F21234}; pl = '{1'b1};
    run_load(1'b0); end_load();

    // Three instructions, load_start overlapped with a valid word.
    pw = '{32'h30F10005, 32'h60130000, 32'h63340000}; pl = '{1'b0, 1'b0, 1'b1};
    run_load(1'b1); end_load();

    // Illegal ifun on the second instruction.
    pw = '{32'h30F10005, 32'h64120000, 32'h60130000}; pl = '{1'b0, 1'b0, 1'b1};
    run_load(1'b0); end_load();

    // Capacity: more legal words than fit, no in_last.
    pw.delete(); pl.delete();
    for (int i = 0; i < DEP + 2; i++) begin
      pw.push_back(rand_instr(1'b0));
      pl.push_back(1'b0);
    end
    run_load(1'b0); end_load();

    // Reset in the middle of a load after two writes.
    log_q.delete();
    @(negedge clock); load_start = 1'b1;
    @(negedge clock); load_start = 1'b0; drive_word(32'h30F00001, 1'b0);
    @(negedge clock); drive_word(32'h60010000, 1'b0);
    @(negedge clock); in_valid = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("mid_n_writes", 32'(log_q.size()), 32'd2);
    check_eq("mid_count", 32'(count), 32'd2);
    reset_n = 1'b0;
    @(negedge clock);
    check_eq("mrst_addr", 32'(addr), 32'd0);
    check_eq("mrst_wen", 32'(wEn), 32'd0);
    check_eq("mrst_wdat", wDat, 32'd0);
    check_eq("mrst_working", 32'(working), 32'd0);
    check_eq("mrst_count", 32'(count), 32'd0);
    check_eq("mrst_ready", 32'(in_ready), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("mrst_idle_ready", 32'(in_ready), 32'd0);
    pw = '{32'h30F3ABCD, 32'h62350000}; pl = '{1'b0, 1'b1};
    run_load(1'b0);

    // In RUN: lone load_start ignored; run_stop wins over a simultaneous load_start.
    load_start = 1'b1;
    @(negedge clock); load_start = 1'b0;
    @(negedge clock);
    check_eq("run_ignore_working", 32'(working), 32'd1);
    check_eq("run_ignore_ready", 32'(in_ready), 32'd0);
    run_stop = 1'b1; load_start = 1'b1;
    @(negedge clock); run_stop = 1'b0; load_start = 1'b0;
    check_eq("stop_working", 32'(working), 32'd0);
    repeat (2) @(negedge clock);
    check_eq("stop_no_load", 32'(in_ready), 32'd0);
    check_eq("stop_no_write", 32'(wEn), 32'd0);

    // Randomized programs.
    for (int t = 0; t < 40; t++) begin
      int len;
      bit long_prog;
      pw.delete(); pl.delete();
      long_prog = ($urandom_range(0, 7) == 0);
      len = long_prog ? DEP + 1 : $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin
        pw.push_back(rand_instr(!long_prog));
        pl.push_back(!long_prog && (i == len - 1));
      end
      run_load($urandom_range(0, 1) == 1);
      end_load();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Instruction encoder and loader for processor Z's instruction RAM; it is the write-side counterpart of the processor's fetch/decode stage.
- Accepts decoded instruction fields (icode, ifun, rA, rB, valC) over a valid/ready stream.
- Validates each instruction against the Z instruction set, packs it into a 32-bit word and drives the processor's addr/wEn/wDat port at sequential addresses.
- After the last instruction it appends the zero terminator word, then asserts working to start execution.

Parameters:
ADDR_W, 9, RAM word-address width; matches the processor addr port.
DEPTH, 512, RAM words available; at most DEPTH-1 instructions plus 1 terminator.

Ports:
clock  in  1  system clock; all logic on posedge.
reset_n  in  1  synchronous, active-low reset.
load_start  in  1  pulse: begin a new program load from address 0 (honoured only in IDLE).
run_stop  in  1  pulse: stop execution (honoured only in RUN).
err_clr  in  1  pulse: leave ERR and return to IDLE.
in_valid  in  1  instruction fields valid.
in_ready  out  1  loader accepts the fields this cycle.
in_icode  in  4  instruction code.
in_ifun  in  4  function code.
in_rA  in  4  source register ID.
in_rB  in  4  destination register ID.
in_valC  in  16  immediate.
in_last  in  1  marks the final instruction of the program.
addr  out  ADDR_W  RAM write address (to processor addr).
wEn  out  1  RAM write enable (to processor wEn).
wDat  out  32  encoded word (to processor wDat).
working  out  1  processor run enable (to processor working).
count  out  ADDR_W+1  instructions written in the current load (terminator excluded).
err  out  1  illegal instruction rejected; sticky until err_clr or reset.
trunc  out  1  program truncated at capacity; cleared by the next load_start or reset.

Behaviour:
- Reset, sampled on posedge clock while reset_n=0:
  - state=IDLE; addr, wEn, wDat, working, count, err and trunc are all 0; the internal write pointer is 0.
  - A reset mid-load abandons the partial program; the RAM contents are left unterminated and working stays 0.
- Encoding: wDat = {icode, ifun, rA, rB, valC}, i.e. [31:28]=icode, [27:24]=ifun, [23:20]=rA, [19:16]=rB, [15:0]=valC.
- Legal instructions; anything else is illegal:
  - IRMOV: icode=3, ifun=0, rA=0xF, rB in 0..5, any valC.
  - OP: icode=6, ifun in 0..3 (ADD/SUB/AND/XOR), rA and rB in 0..5, valC=0.
  - No legal instruction encodes to 0x00000000, so the terminator is unambiguous.
- States:
  - IDLE: in_ready=0, wEn=0, working=0. On load_start, clear the pointer, count and trunc, then go to LOAD.
  - LOAD: in_ready=1.
    - On in_valid with a legal instruction: the next cycle drives wEn=1, addr=pointer, wDat=encoded; then pointer+1 and count+1.
    - The write is registered, so output latency is 1 cycle after the handshake. wEn is a single-cycle pulse per accepted instruction.
    - With in_last=1, go to TERM.
    - When the accepted instruction brings count to DEPTH-1 without in_last, set trunc=1 and go to TERM.
    - An illegal instruction is accepted (the handshake completes) but not written: err=1, go to ERR, in_ready=0.
    - in_valid=0 holds the state; wEn=0.
  - TERM: one cycle with in_ready=0, wEn=1, addr=pointer, wDat=0; then go to RUN.
  - RUN: working=1, wEn=0, in_ready=0, addr=0. On run_stop, working=0 the next cycle and go to IDLE.
  - ERR: working=0, in_ready=0, wEn=0. On err_clr, clear err and go to IDLE.
- Simultaneous events:
  - Every write completes before working rises; wEn and working are never both 1 in the same cycle.
  - load_start outside IDLE, run_stop outside RUN and err_clr outside ERR are ignored.
  - In IDLE, load_start with in_valid=1 in the same cycle is not a handshake; in_ready only rises the cycle after.
- The addr width covers the full DEPTH; the pointer never wraps.

Test Plan:
- Reset, load_start, then IRMOV {3,0,F,2,0x1234} with in_last=1 -> addr0 wDat=0x30F21234 wEn pulse; next cycle addr1 wDat=0 wEn=1; then working=1, count=1.
- Load IRMOV {3,0,F,1,0x0005}, ADD {6,0,1,3,0}, XOR {6,3,3,4,0} last, with in_valid gaps -> words 0x30F10005, 0x60130000, 0x63340000 at addr 0..2, 0 at addr 3; wEn only on accepted cycles; count=3.
- Load with second instruction {6,4,1,2,0} (ifun 4 illegal) -> only addr0 written, err=1, working stays 0; err_clr -> IDLE, err=0.
- DEPTH=4, four legal instructions without in_last -> 3 written at addr 0..2, terminator at addr 3, trunc=1, in_ready=0 after the 3rd, working=1.
- reset_n=0 during LOAD after 2 writes -> all outputs 0 next cycle, state IDLE; a new load_start restarts at addr 0 with count=0.
- In RUN: load_start alone -> ignored, working stays 1; run_stop and load_start in the same cycle -> working=0, IDLE, no load started.
